// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encodings and default sizing
// for the stall controller, forwarding unit and hazard unit.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_t;

    localparam int DEF_MD_TIMEOUT = 64;
    localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/pipeline_stall_controller_wait_timer.sv
// Clearable up-counter with a terminal-count flag at TC-1; bounds the
// multiply/divide wait.
module wait_timer #(
    parameter int TC = 64,
    parameter int W  = $clog2(TC)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    assign tc = (count == W'(TC - 1));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Prioritised stall/freeze/flush sequencer driving every pipeline register
// enable; Mealy outputs so a hazard stalls in the cycle it is raised.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int BR_FLUSH_DEPTH = 1,
    parameter int MD_TIMEOUT     = DEF_MD_TIMEOUT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_bubble,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             md_timeout
);

    ctrl_state_t cur, nxt;
    logic        timer_tc;
    logic        timeout_hit;

    // Timer sits at zero throughout RUN, so it is already loaded when MD_WAIT begins.
    wait_timer #(.TC(MD_TIMEOUT)) u_md_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cur == RUN),
        .en    (cur == MD_WAIT),
        .tc    (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            cur <= RUN;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt          = cur;
        timeout_hit  = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        exmem_bubble = 1'b0;
        memwb_bubble = 1'b0;
        unique case (cur)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    {pc_write, ifid_write, idex_write, exmem_write} = '0;
                    memwb_bubble = 1'b1;
                    nxt          = MEM_WAIT;
                end else if (md_start) begin
                    {pc_write, ifid_write, idex_write} = '0;
                    exmem_bubble = 1'b1;
                    nxt          = MD_WAIT;
                end else if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = (BR_FLUSH_DEPTH >= 2);
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
            end
            MD_WAIT: begin
                if (md_done) begin
                    nxt = RUN;
                end else if (timer_tc) begin
                    timeout_hit = 1'b1;
                    nxt         = RUN;
                end else begin
                    {pc_write, ifid_write, idex_write} = '0;
                    exmem_bubble = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    nxt = RUN;
                end else begin
                    {pc_write, ifid_write, idex_write, exmem_write} = '0;
                    memwb_bubble = 1'b1;
                end
            end
            default: nxt = RUN;
        endcase
        // Reset holds every stage frozen and fills the pipe with NOPs.
        if (!rst_n) begin
            {pc_write, ifid_write, idex_write, exmem_write} = '0;
            {ifid_flush, idex_bubble, exmem_bubble, memwb_bubble} = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            md_timeout   <= 1'b0;
        end else begin
            if (!pc_write && stall_cycles != {CNT_W{1'b1}})
                stall_cycles <= stall_cycles + 1'b1;
            if (timeout_hit)
                md_timeout <= 1'b1;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: each driven cycle pushes its hand-computed expectation and
// a negedge monitor pops and compares it against the DUT.
module tb_pipeline_stall_controller;

    localparam int CW = 4;

    // Enable vector order: pc, ifid, ifid_flush, idex, idex_bubble, exmem, exmem_bubble, memwb_bubble
    localparam logic [7:0] BASE = 8'b1101_0100;
    localparam logic [7:0] MEMF = 8'b0000_0001;
    localparam logic [7:0] MDF  = 8'b0000_0110;
    localparam logic [7:0] BRF  = 8'b1111_1100;
    localparam logic [7:0] LUS  = 8'b0001_1100;
    localparam logic [7:0] RSTO = 8'b0010_1011;

    // Input vector order: load_use, branch_taken, md_start, md_done, dmem_req, dmem_ready
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] LU   = 6'b100000;
    localparam logic [5:0] BR   = 6'b010000;
    localparam logic [5:0] MS   = 6'b001000;
    localparam logic [5:0] MD   = 6'b000100;
    localparam logic [5:0] DR   = 6'b000010;
    localparam logic [5:0] DY   = 6'b000001;

    typedef struct packed {
        logic [7:0]    en;
        logic [1:0]    st;
        logic [CW-1:0] sc;
        logic          mt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use = 1'b0, branch_taken = 1'b0, md_start = 1'b0, md_done = 1'b0;
    logic dmem_req = 1'b0, dmem_ready = 1'b0;
    logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic exmem_write, exmem_bubble, memwb_bubble, md_timeout;
    logic [1:0]    state;
    logic [CW-1:0] stall_cycles;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .BR_FLUSH_DEPTH (2),
        .MD_TIMEOUT     (6),
        .CNT_W          (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_use     (load_use),
        .branch_taken (branch_taken),
        .md_start     (md_start),
        .md_done      (md_done),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_write   (idex_write),
        .idex_bubble  (idex_bubble),
        .exmem_write  (exmem_write),
        .exmem_bubble (exmem_bubble),
        .memwb_bubble (memwb_bubble),
        .state        (state),
        .stall_cycles (stall_cycles),
        .md_timeout   (md_timeout)
    );

    task automatic step(input logic r, input logic [5:0] in, input logic [7:0] en,
                        input logic [1:0] st, input logic [CW-1:0] sc, input logic mt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        {load_use, branch_taken, md_start, md_done, dmem_req, dmem_ready} = in;
        e.en = en; e.st = st; e.sc = sc; e.mt = mt;
        sb.push_back(e);
    endtask

    // Monitor: one expectation per driven cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                   exmem_write, exmem_bubble, memwb_bubble};
            n_vec++;
            if (act !== e.en) begin
                n_bad++;
                $display("FAIL enables t=%0t actual=%b required=%b", $time, act, e.en);
            end
            n_vec++;
            if (state !== e.st) begin
                n_bad++;
                $display("FAIL state t=%0t actual=%0d required=%0d", $time, state, e.st);
            end
            n_vec++;
            if (stall_cycles !== e.sc) begin
                n_bad++;
                $display("FAIL stall_cycles t=%0t actual=%0d required=%0d", $time, stall_cycles, e.sc);
            end
            n_vec++;
            if (md_timeout !== e.mt) begin
                n_bad++;
                $display("FAIL md_timeout t=%0t actual=%b required=%b", $time, md_timeout, e.mt);
            end
        end
    end

    initial begin
        // Reset, load-use stall, branch overriding load-use
        step(0, NONE, RSTO, 0, 0, 0);
        step(1, LU,   LUS,  0, 0, 0);
        step(1, NONE, BASE, 0, 1, 0);
        step(1, BR|LU, BRF, 0, 1, 0);
        step(1, NONE, BASE, 0, 1, 0);
        step(0, NONE, RSTO, 0, 1, 0);
        // md_start at cycle 0, md_done at cycle 5; hazards ignored while waiting
        step(1, MS,   MDF,  0, 0, 0);
        step(1, NONE, MDF,  1, 1, 0);
        step(1, LU|BR|DR, MDF, 1, 2, 0);
        step(1, NONE, MDF,  1, 3, 0);
        step(1, NONE, MDF,  1, 4, 0);
        step(1, MD,   BASE, 1, 5, 0);
        step(1, NONE, BASE, 0, 5, 0);
        // Timeout after 6 MD_WAIT cycles, sticky flag, re-entry still works
        step(1, MS,   MDF,  0, 5, 0);
        for (int i = 0; i < 5; i++)
            step(1, NONE, MDF, 1, CW'(6 + i), 0);
        step(1, NONE, BASE, 1, 11, 0);
        step(1, NONE, BASE, 0, 11, 1);
        step(1, MS,   MDF,  0, 11, 1);
        step(1, MD,   BASE, 1, 12, 1);
        step(1, NONE, BASE, 0, 12, 1);
        // md_done coincident with terminal count wins; flag stays clear
        step(0, NONE, RSTO, 0, 12, 1);
        step(1, MS,   MDF,  0, 0, 0);
        for (int i = 0; i < 5; i++)
            step(1, NONE, MDF, 1, CW'(1 + i), 0);
        step(1, MD,   BASE, 1, 6, 0);
        step(1, NONE, BASE, 0, 6, 0);
        // Memory wait beats md_start; md_start re-presented after release
        step(1, DR|MS, MEMF, 0, 6, 0);
        step(1, DR|MS, MEMF, 2, 7, 0);
        step(1, DR|MS, MEMF, 2, 8, 0);
        step(1, DR|DY|MS, BASE, 2, 9, 0);
        step(1, MS,   MDF,  0, 9, 0);
        step(1, MD,   BASE, 1, 10, 0);
        step(1, NONE, BASE, 0, 10, 0);
        // Reset in MEM_WAIT aborts and clears counters
        step(1, DR,   MEMF, 0, 10, 0);
        step(1, DR,   MEMF, 2, 11, 0);
        step(0, DR,   RSTO, 2, 12, 0);
        step(1, NONE, BASE, 0, 0, 0);
        // Saturation of stall_cycles at all-ones
        for (int i = 0; i < 18; i++)
            step(1, LU, LUS, 0, (i > 15) ? CW'(15) : CW'(i), 0);
        step(1, NONE, BASE, 0, 15, 0);
        step(0, LU,   RSTO, 0, 15, 0);
        step(1, NONE, BASE, 0, 0, 0);
        for (int i = 0; i < 20 && sb.size() > 0; i++)
            @(posedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Cycle-level sequencer for the MIPS pipeline's stall, freeze and flush controls. It merges the load-use hazard flag, taken-branch redirects, multi-cycle multiply/divide waits and data-memory wait states into one prioritised set of per-register write, flush and bubble enables. It sits between the hazard/forwarding logic and the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and is the only block that drives their enables.

## Interface

Parameters:
- BR_FLUSH_DEPTH, 1, pipeline stages squashed on a taken branch (1 = IF/ID only; 2 = IF/ID and ID/EX)
- MD_TIMEOUT, 64, maximum MD_WAIT cycles before abort; legal range 2..65535
- CNT_W, 16, width of stall_cycles

Clock and reset:
- One clock, `clk`; reset `rst_n` is synchronous and active-low.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- load_use  in  1  load-use hazard flag from hazard detection
- branch_taken  in  1  branch/jump resolved taken this cycle
- md_start  in  1  multiply/divide issued in EX this cycle
- md_done  in  1  multiply/divide result valid
- dmem_req  in  1  data-memory access in MEM this cycle
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads NOP control
- exmem_write  out  1  EX/MEM load enable
- exmem_bubble  out  1  EX/MEM loads NOP control
- memwb_bubble  out  1  MEM/WB loads NOP control
- state  out  2  current state: RUN=0, MD_WAIT=1, MEM_WAIT=2
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0
- md_timeout  out  1  sticky: MD_WAIT aborted by timeout

## Operation

- Outputs are Mealy, combinational from state and inputs, so stalls take effect in the cycle the condition is raised.
- Baseline (no event): all writes 1, all flush/bubble 0.
- RUN, evaluated in priority order; highest active condition wins:
  - MEM: dmem_req & !dmem_ready. Freeze: pc/ifid/idex/exmem writes 0, memwb_bubble=1. Next state MEM_WAIT.
  - MD: md_start. pc/ifid/idex writes 0, exmem_bubble=1. Next state MD_WAIT; timer loads 0.
  - Branch: branch_taken. Outputs = baseline + ifid_flush=1; idex_bubble=1 only if BR_FLUSH_DEPTH=2. Stays RUN. Overrides a coincident load_use.
  - Load-use: load_use. pc_write=0, ifid_write=0, idex_bubble=1. Stays RUN.
- MD_WAIT:
  - Outputs as the MD freeze until md_done=1.
  - In the md_done cycle, outputs = baseline; next state RUN.
  - Timer increments each cycle. Reaching MD_TIMEOUT-1 without md_done: outputs baseline that cycle, md_timeout set, next state RUN.
  - md_done wins over a coincident timeout.
- MEM_WAIT:
  - Outputs as the MEM freeze while dmem_ready=0.
  - In the dmem_ready cycle, outputs = baseline; next state RUN.
- In MD_WAIT and MEM_WAIT, load_use, branch_taken, md_start and dmem_req are ignored; frozen stages re-present them after release.
- stall_cycles increments on every cycle with pc_write=0 (including rst_n=0 cycles is excluded, see reset) and saturates at all-ones.
- md_timeout stays set until reset.

## Timing

- Reset (rst_n=0 at a rising edge):
  - Next state RUN; stall_cycles=0, md_timeout=0, timer=0.
  - While rst_n=0, outputs are forced: pc_write, ifid_write, idex_write and exmem_write = 0; ifid_flush, idex_bubble, exmem_bubble and memwb_bubble = 1.
  - stall_cycles does not count during reset.
- Reset mid-MD_WAIT or mid-MEM_WAIT aborts immediately; md_timeout is not set.
- Stall latency is 0 cycles (same-cycle enables). Release takes effect in the completion cycle; the state update is visible 1 cycle later.
- MD_WAIT total freeze length = 1 (md_start cycle) + cycles until md_done, bounded by MD_TIMEOUT.

## Structure

- Shared package pipeline_ctrl_pkg holds the state encodings (RUN/MD_WAIT/MEM_WAIT) and the default MD_TIMEOUT and CNT_W. The forwarding and hazard blocks reuse them.
- One sub-module, wait_timer: clearable up-counter with terminal-count flag, used for the MD timeout.
- The FSM, priority mux and stall counter live in the top module.

## Test plan

- load_use=1 for 1 cycle in RUN -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; stall_cycles 0->1; state stays 0.
- branch_taken=1 and load_use=1 together, BR_FLUSH_DEPTH=2 -> pc_write=1, ifid_flush=1, idex_bubble=1; stall_cycles unchanged.
- md_start at cycle 0, md_done at cycle 5 -> cycles 0-4 frozen with exmem_bubble=1, cycle 5 baseline, state returns to 0 at cycle 6; stall_cycles=5.
- md_start with MD_TIMEOUT=4 and no md_done -> abort after 4 MD_WAIT cycles; md_timeout=1 persists; a later md_start still enters MD_WAIT.
- dmem_req=1, dmem_ready=0 for 3 cycles while md_start=1 -> MEM wins, state 2, memwb_bubble=1; release on dmem_ready; md_start re-presented then enters MD_WAIT.
- rst_n=0 during MEM_WAIT -> next state 0, counters cleared, forced reset outputs; stall_cycles preset near saturation stays at 0xFFFF when incremented.
